// File: rtl/dbg_guv_pkg.sv
// Shared definitions for the dbg_guv command chain: word width, FSM encodings
// and a width helper.
package dbg_guv_pkg;

  localparam int unsigned CMD_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // $clog2 that never returns 0, so counters always have at least one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/dbg_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO, 2**AW entries, active-low
// synchronous reset.
module dbg_cmd_fifo
  import dbg_guv_pkg::*;
#(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = CMD_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  // Occupancy never exceeds DEPTH, so the MSB alone marks full.
  assign full  = count[AW];
  assign empty = (count == '0);

endmodule

// File: rtl/dbg_cmd_tx.sv
// Host-side initiator for the dbg_guv command chain: buffers host words and
// launches them with a minimum idle gap. Optional stats via DBG_CMD_TX_STATS_EN.
module dbg_cmd_tx
  import dbg_guv_pkg::*;
#(
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned PIPE_STAGE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CMD_WIDTH-1:0] host_TDATA,
  input  logic                 host_TVALID,
  output logic                 host_TREADY,
  input  logic                 hold,
  output logic [CMD_WIDTH-1:0] cmd_out_TDATA,
  output logic                 cmd_out_TVALID,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 busy
`ifdef DBG_CMD_TX_STATS_EN
  ,
  output logic [31:0]          sent_count,
  output logic                 hold_stall
`endif
);

  localparam int unsigned GW = clog2_min1(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  logic                 full;
  logic                 empty;
  logic                 pop;
  logic [CMD_WIDTH-1:0] fifo_dout;
  state_e               state;
  logic [GW-1:0]        gap_cnt;
  logic [CMD_WIDTH-1:0] out_data;
  logic                 out_valid;

  assign host_TREADY = rst && !full;

  dbg_cmd_fifo #(
    .AW(FIFO_AW),
    .DW(CMD_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (host_TVALID && host_TREADY),
    .pop  (pop),
    .din  (host_TDATA),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (full),
    .empty(empty)
  );

  // The last gap cycle may launch directly, so the idle gap is exactly GAP_CYCLES.
  always_comb begin
    pop = 1'b0;
    unique case (state)
      ST_IDLE: pop = !empty && !hold;
      ST_SEND: pop = (GAP_CYCLES == 0) && !empty && !hold;
      ST_GAP:  pop = (gap_cnt == '0) && !empty && !hold;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= pop;
      if (pop) out_data <= fifo_dout;
      unique case (state)
        ST_IDLE: if (pop) state <= ST_SEND;
        ST_SEND: begin
          if (GAP_CYCLES != 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end else if (!pop) begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= pop ? ST_SEND : ST_IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  if (PIPE_STAGE != 0) begin : g_pipe
    logic [CMD_WIDTH-1:0] pipe_data;
    logic                 pipe_valid;
    always_ff @(posedge clk) begin
      if (!rst) begin
        pipe_data  <= '0;
        pipe_valid <= 1'b0;
      end else begin
        pipe_valid <= out_valid;
        if (out_valid) pipe_data <= out_data;
      end
    end
    assign cmd_out_TDATA  = pipe_data;
    assign cmd_out_TVALID = pipe_valid;
  end else begin : g_direct
    assign cmd_out_TDATA  = out_data;
    assign cmd_out_TVALID = out_valid;
  end

  assign busy = !empty || (state != ST_IDLE);

`ifdef DBG_CMD_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst)                sent_count <= '0;
    else if (cmd_out_TVALID) sent_count <= sent_count + 32'd1;
  end
  assign hold_stall = (state == ST_IDLE) && !empty && hold;
`endif

endmodule

// File: tb/tb_dbg_cmd_tx.sv
// Bench for dbg_cmd_tx: one back-to-back and one gapped instance share inputs and
// are compared each cycle against an "emit as early as allowed" queue model.
module tb_dbg_cmd_tx;

  localparam int G0 = 0;
  localparam int G1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        hold = 1'b0;

  logic [1:0][31:0] o_data;
  logic [1:0]       o_valid;
  logic [1:0]       o_ready;
  logic [1:0]       o_busy;
  logic [1:0][4:0]  o_count;
`ifdef DBG_CMD_TX_STATS_EN
  logic [1:0][31:0] sent;
  logic [1:0]       stall;
`endif

  dbg_cmd_tx #(.FIFO_AW(4), .GAP_CYCLES(G0), .PIPE_STAGE(0)) u_dut0 (
    .clk           (clk),
    .rst           (rst),
    .host_TDATA    (tdata),
    .host_TVALID   (tvalid),
    .host_TREADY   (o_ready[0]),
    .hold          (hold),
    .cmd_out_TDATA (o_data[0]),
    .cmd_out_TVALID(o_valid[0]),
    .fifo_count    (o_count[0]),
    .busy          (o_busy[0])
`ifdef DBG_CMD_TX_STATS_EN
    ,
    .sent_count    (sent[0]),
    .hold_stall    (stall[0])
`endif
  );

  dbg_cmd_tx #(.FIFO_AW(4), .GAP_CYCLES(G1), .PIPE_STAGE(0)) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .host_TDATA    (tdata),
    .host_TVALID   (tvalid),
    .host_TREADY   (o_ready[1]),
    .hold          (hold),
    .cmd_out_TDATA (o_data[1]),
    .cmd_out_TVALID(o_valid[1]),
    .fifo_count    (o_count[1]),
    .busy          (o_busy[1])
`ifdef DBG_CMD_TX_STATS_EN
    ,
    .sent_count    (sent[1]),
    .hold_stall    (stall[1])
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at t=%0t: got %h expected %h", nm, i, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int          last_strobe[2];
  logic [31:0] m_data[2];
  logic        m_valid[2];
  int          accepted[2];
  int          emitted[2];
  int          cyc = 0;
  bit          dp;

  function automatic int gap(input int i);
    return (i == 0) ? G0 : G1;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int i, input logic [31:0] w);
    if (i == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  task automatic qpop(input int i, output logic [31:0] w);
    if (i == 0) w = q0.pop_front();
    else        w = q1.pop_front();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      last_strobe[i] = -1000;
      m_data[i] = '0;
      m_valid[i] = 1'b0;
      accepted[i] = 0;
      emitted[i] = 0;
    end
  end

  // A word launches at the first edge where it is buffered, hold is low and at
  // least gap() idle cycles have followed the previous strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        if (i == 0) q0.delete();
        else        q1.delete();
        last_strobe[i] = -1000;
        m_data[i] = '0;
        m_valid[i] = 1'b0;
        accepted[i] = 0;
        emitted[i] = 0;
      end else begin
        dp = tvalid && (qsize(i) < 16);
        if (qsize(i) > 0 && !hold && (cyc + 1 - last_strobe[i]) >= gap(i) + 1) begin
          qpop(i, m_data[i]);
          m_valid[i] = 1'b1;
          last_strobe[i] = cyc + 1;
          emitted[i]++;
        end else begin
          m_valid[i] = 1'b0;
        end
        if (dp) begin
          qpush(i, tdata);
          accepted[i]++;
        end
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk("tvalid", i, 32'(o_valid[i]), 32'(m_valid[i]));
      chk("tdata", i, o_data[i], m_data[i]);
      chk("fifo_count", i, 32'(o_count[i]), 32'(qsize(i)));
      chk("tready", i, 32'(o_ready[i]), 32'(rst && (qsize(i) < 16)));
      chk("busy", i, 32'(o_busy[i]),
          32'((qsize(i) > 0) || ((cyc - last_strobe[i]) <= gap(i))));
    end
  end

  // Strobe log for ordering and spacing checks.
  int          lcyc0[$];
  int          lcyc1[$];
  logic [31:0] ldat0[$];
  logic [31:0] ldat1[$];

  always @(negedge clk) begin
    if (o_valid[0]) begin lcyc0.push_back(cyc); ldat0.push_back(o_data[0]); end
    if (o_valid[1]) begin lcyc1.push_back(cyc); ldat1.push_back(o_data[1]); end
  end

  task automatic clear_logs();
    lcyc0.delete(); lcyc1.delete(); ldat0.delete(); ldat1.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) step();
  endtask

  typedef struct {
    logic        rst;
    logic        tv;
    logic [31:0] d;
    logic        hold;
    logic        e_ready;
    logic        e_valid;
    logic [31:0] e_data;
    logic [4:0]  e_count;
  } vec_t;

  vec_t tbl[6];
  int   n;
  bit   found;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b0, 32'h0,         5'd0};
    tbl[1] = '{1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 1'b0, 32'h0,         5'd0};
    tbl[2] = '{1'b1, 1'b1, 32'hA000_0001, 1'b0, 1'b1, 1'b0, 32'h0,         5'd0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         5'd1};
    tbl[4] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'hA000_0001, 5'd0};
    tbl[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA000_0001, 5'd0};

    step();
    // Reset release and first-word latency.
    for (int k = 0; k < 6; k++) begin
      rst = tbl[k].rst; tvalid = tbl[k].tv; tdata = tbl[k].d; hold = tbl[k].hold;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("tbl_ready", i, 32'(o_ready[i]), 32'(tbl[k].e_ready));
        chk("tbl_valid", i, 32'(o_valid[i]), 32'(tbl[k].e_valid));
        chk("tbl_data", i, o_data[i], tbl[k].e_data);
        chk("tbl_count", i, 32'(o_count[i]), 32'(tbl[k].e_count));
      end
      step();
    end
    idle(5);

    // Back-to-back words on the GAP_CYCLES=0 instance.
    clear_logs();
    tvalid = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      tdata = 32'(w);
      step();
    end
    idle(30);
    chk("b2b_len", 0, 32'(ldat0.size()), 32'd5);
    for (int k = 0; k < ldat0.size() && k < 5; k++) begin
      chk("b2b_data", 0, ldat0[k], 32'(k + 1));
      if (k > 0) chk("b2b_spacing", 0, 32'(lcyc0[k] - lcyc0[k-1]), 32'd1);
    end

    // Gapped words: three idle cycles between strobes.
    clear_logs();
    tvalid = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tdata = 32'h10 + 32'(w);
      step();
    end
    idle(30);
    chk("gap_len", 1, 32'(ldat1.size()), 32'd3);
    for (int k = 0; k < ldat1.size() && k < 3; k++) begin
      chk("gap_data", 1, ldat1[k], 32'h10 + 32'(k));
      if (k > 0) chk("gap_spacing", 1, 32'(lcyc1[k] - lcyc1[k-1]), 32'd4);
    end

    // Hold fills the FIFO; release drains it in order.
    clear_logs();
    hold = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      tvalid = 1'b1;
      tdata = 32'h100 + 32'(n);
      @(negedge clk);
      if (o_ready[0]) n++;
      step();
    end
    @(negedge clk);
    chk("hold_accepted", 0, 32'(n), 32'd16);
    chk("hold_count", 0, 32'(o_count[0]), 32'd16);
    chk("hold_ready", 0, 32'(o_ready[0]), 32'd0);
    chk("hold_no_emit", 0, 32'(ldat0.size()), 32'd0);
    step();
    hold = 1'b0;
    for (int c = 0; c < 200 && n < 20; c++) begin
      tvalid = 1'b1;
      tdata = 32'h100 + 32'(n);
      @(negedge clk);
      if (o_ready[0]) n++;
      step();
    end
    chk("hold_all_accepted", 0, 32'(n), 32'd20);
    idle(40);
    chk("hold_len", 0, 32'(ldat0.size()), 32'd20);
    for (int k = 0; k < ldat0.size() && k < 20; k++) begin
      chk("hold_order", 0, ldat0[k], 32'h100 + 32'(k));
    end

    // Random traffic with frequent full-FIFO push/pop overlap.
    for (int c = 0; c < 1000; c++) begin
      tvalid = ($urandom_range(9) < 8);
      hold = ($urandom_range(9) < 2);
      tdata = $urandom;
      step();
    end
    hold = 1'b0;
    idle(100);
    for (int i = 0; i < 2; i++) begin
      chk("rand_drain", i, 32'(emitted[i]), 32'(accepted[i]));
`ifdef DBG_CMD_TX_STATS_EN
      chk("sent_count", i, sent[i], 32'(emitted[i]));
`endif
    end

    // Reset while the gapped instance holds 7 words and sits in GAP.
    hold = 1'b1;
    tvalid = 1'b1;
    for (int w = 0; w < 8; w++) begin
      tdata = 32'h200 + 32'(w);
      step();
    end
    tvalid = 1'b0;
    hold = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (o_valid[1]) found = 1'b1;
      step();
    end
    if (!found) begin
      errors++;
      $display("FAIL midrst_wait dut1: got no strobe expected one within 20 cycles");
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_pre_count", 1, 32'(o_count[1]), 32'd7);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_count", 1, 32'(o_count[1]), 32'd0);
    chk("midrst_valid", 1, 32'(o_valid[1]), 32'd0);
    chk("midrst_busy", 1, 32'(o_busy[1]), 32'd0);
    clear_logs();
    idle(30);
    chk("midrst_stale0", 0, 32'(ldat0.size()), 32'd0);
    chk("midrst_stale1", 1, 32'(ldat1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbg_cmd_tx.md
Name: dbg_cmd_tx

Overview:
- Host-side initiator for the dbg_guv command daisy-chain.
- Accepts 32-bit command words from a host AXI-Stream that has backpressure.
- Buffers them in a small FIFO and drives the head of the chain (cmd_out_TDATA/TVALID). The chain has no TREADY.
- Enforces a programmable minimum idle gap between words so downstream governors and their PIPE_STAGE registers are never overrun.

Parameters:
- FIFO_AW, 4, log2 of FIFO depth; depth is 2**FIFO_AW = 16 words.
- GAP_CYCLES, 0, minimum idle cycles after each emitted word; 0 means back-to-back.
- PIPE_STAGE, 0, 1 adds one output register stage, so latency +1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets).
- host_TDATA  in  32  command word from host.
- host_TVALID  in  1  host word valid.
- host_TREADY  out  1  high when FIFO not full.
- hold  in  1  1 = do not launch new words; FIFO keeps accepting.
- cmd_out_TDATA  out  32  command word to first dbg_guv cmd_in.
- cmd_out_TVALID  out  1  single-cycle strobe per word; no backpressure.
- fifo_count  out  FIFO_AW+1  current FIFO occupancy.
- busy  out  1  FIFO non-empty OR FSM not IDLE.

Behaviour:
- Reset (rst==0 at an edge):
  - FIFO emptied; fifo_count=0.
  - cmd_out_TVALID=0, cmd_out_TDATA=0, busy=0, FSM=IDLE, gap counter=0.
  - host_TREADY=0 while rst==0; it goes to 1 on the first cycle after release.
  - Reset mid-operation discards all buffered words; no partial output.
- Host handshake:
  - A push occurs on any edge with host_TVALID & host_TREADY.
  - host_TREADY = !full (registered-count based, so no combinational path from host_TVALID).
- FIFO:
  - First-word-fall-through head, RAM or register array.
  - Push and pop on the same edge: count unchanged, both take effect.
  - Push when full is impossible (TREADY=0).
  - Pop when empty never occurs.
  - Pointers wrap modulo 2**FIFO_AW; full when count == 2**FIFO_AW.
- FSM, IDLE / SEND / GAP:
  - IDLE: if count>0 and hold==0, pop the head into the output register and go to SEND; otherwise stay.
  - SEND (one cycle): output register drives cmd_out_TVALID=1.
    - GAP_CYCLES==0 and count>0 and hold==0: pop the next word and stay in SEND, giving back-to-back words.
    - GAP_CYCLES==0 otherwise: go to IDLE.
    - GAP_CYCLES>0: load the gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP: cmd_out_TVALID=0; decrement the counter; at 0 go to IDLE.
- hold:
  - Sampled only in IDLE and at the end of SEND; never truncates a word.
- Outputs:
  - cmd_out_TDATA holds its last value when TVALID==0.
- Latency (empty FIFO, IDLE, hold==0, PIPE_STAGE=0):
  - A word handshaken in cycle c appears with cmd_out_TVALID=1 in cycle c+2.
  - PIPE_STAGE=1 gives c+3.
- Ordering: strict FIFO order; no word dropped or duplicated.
- Gap counter width: $clog2(GAP_CYCLES+1), minimum 1.

Optional Feature:
- Macro: DBG_CMD_TX_STATS_EN.
- Defined: adds output sent_count (32 bits).
  - Increments on every cycle with cmd_out_TVALID=1, wraps at 2**32.
  - Reset to 0.
  - Also adds output hold_stall (1 bit), high when count>0 and hold==1 in IDLE.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package dbg_guv_pkg holds:
  - CMD_WIDTH=32;
  - FSM state encodings ST_IDLE=0, ST_SEND=1, ST_GAP=2 (2-bit);
  - a helper function clog2_min1.
- One sub-module, dbg_cmd_fifo: synchronous FWFT FIFO with parameter AW and ports push/pop/din/dout/count/full/empty, using the same active-low sync reset.

Test Plan:
- Reset release with host_TVALID=1: host_TREADY=0 during reset, 1 on the first cycle after. Word 0xA0000001 pushed in cycle c gives cmd_out_TVALID=1, TDATA=0xA0000001 in cycle c+2 only.
- GAP_CYCLES=0, push 5 words 0x1..0x5 back-to-back: five consecutive TVALID cycles carrying 0x1..0x5 in order.
- GAP_CYCLES=3, push 0x10, 0x11, 0x12: exactly 3 idle cycles between successive TVALID strobes.
- hold=1, push 20 words: host_TREADY drops after 16 pushes, fifo_count=16, no TVALID. Release hold: all 16 words emitted in order, then the remaining 4 are accepted and emitted in order.
- Simultaneous push/pop with count=16 at steady state: count stays consistent and no word is lost. Compare against a scoreboard over 1000 random host_TVALID/hold cycles.
- rst=0 asserted while count=7 and FSM in GAP: next cycle count=0, TVALID=0, busy=0. After release, no stale word is emitted.
